// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
package md_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

  function automatic logic md_op1_signed(input logic [2:0] funct3);
    return (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
           (funct3 == MD_DIV)  || (funct3 == MD_REM);
  endfunction

  function automatic logic md_op2_signed(input logic [2:0] funct3);
    return (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
  endfunction

endpackage

// File: rtl/md_core.sv
// One-bit-per-step datapath: shift-add multiply / restoring divide sharing a
// 2*XLEN accumulator, with final sign fix and result-field select.
module md_core
  import md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_finish,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic [XLEN-1:0] o_result_c
);

  logic [2:0]        r_funct3;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic              r_neg;

  logic              w_s1, w_s2;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;

  assign w_s1   = md_op1_signed(i_funct3) & i_op1[XLEN-1];
  assign w_s2   = md_op2_signed(i_funct3) & i_op2[XLEN-1];
  assign w_mag1 = w_s1 ? (XLEN'(0) - i_op1) : i_op1;
  assign w_mag2 = w_s2 ? (XLEN'(0) - i_op2) : i_op2;

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign w_sum = r_acc[0] ? ({1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mcand})
                          : {1'b0, r_acc[2*XLEN-1:XLEN]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge    = w_shift >= {1'b0, r_mcand};
  assign w_sub   = w_shift[XLEN-1:0] - r_mcand;

  always_comb begin
    w_next = r_acc;
    if (md_is_div(r_funct3)) begin
      if (w_ge) w_next = {w_sub, r_acc[XLEN-2:0], 1'b1};
      else      w_next = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_next = {w_sum, r_acc[XLEN-1:1]};
    end
  end

  assign w_prod = r_neg ? ((2*XLEN)'(0) - w_next) : w_next;
  assign w_quo  = r_neg ? (XLEN'(0) - w_next[XLEN-1:0]) : w_next[XLEN-1:0];
  assign w_rem  = r_neg ? (XLEN'(0) - w_next[2*XLEN-1:XLEN]) : w_next[2*XLEN-1:XLEN];

  always_comb begin
    o_result_c = '0;
    if (i_finish) begin
      case (r_funct3)
        MD_MUL:                            o_result_c = w_prod[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU:      o_result_c = w_prod[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:                   o_result_c = w_quo;
        default:                           o_result_c = w_rem;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      r_funct3 <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_neg    <= 1'b0;
    end else if (i_load) begin
      r_funct3 <= i_funct3;
      r_acc    <= {XLEN'(0), w_mag1};
      r_mcand  <= w_mag2;
      r_neg    <= md_is_rem(i_funct3) ? w_s1 : (w_s1 ^ w_s2);
    end else if (i_step) begin
      r_acc    <= w_next;
    end
  end

endmodule

// File: rtl/md_seq.sv
// Execute-stage sequencer for the iterative multiply/divide unit: FSM, step
// counter, divide special cases and pipeline stall/valid handshakes.
module md_seq
  import md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            md_start,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_op1,
  input  logic [XLEN-1:0] md_op2,
  input  logic            md_flush,
  input  logic            md_hold,
  output logic            mult_stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_valid
);

  localparam int unsigned CW = $clog2(XLEN);

  md_state_t       r_state;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_step;
  logic            w_finish;
  logic            w_divzero;
  logic            w_ovf;
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_special_val;
  logic [XLEN-1:0] w_core_result;

  assign w_accept = (r_state == MD_IDLE) & md_start & ~md_flush;
  assign w_step   = (r_state == MD_CALC) & ~md_flush;
  assign w_finish = w_step & (r_cnt == '0);

  assign w_min     = {1'b1, {(XLEN-1){1'b0}}};
  assign w_divzero = md_is_div(md_funct3) && (md_op2 == '0);
  assign w_ovf     = md_is_div(md_funct3) && md_op1_signed(md_funct3) &&
                     (md_op1 == w_min) && (md_op2 == '1);

  always_comb begin
    w_special_val = '0;
    if (w_divzero)  w_special_val = md_is_rem(md_funct3) ? md_op1 : '1;
    else if (w_ovf) w_special_val = md_is_rem(md_funct3) ? '0 : w_min;
  end

  // Stall is combinational so a newly presented instruction freezes the front end in its first cycle.
  assign mult_stall = w_accept | (r_state == MD_CALC);

  md_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .cpurst     (cpurst),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_finish   (w_finish),
    .i_funct3   (md_funct3),
    .i_op1      (md_op1),
    .i_op2      (md_op2),
    .o_result_c (w_core_result)
  );

  always_ff @(posedge clk) begin
    if (cpurst) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      md_result <= '0;
      md_valid  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            if (w_divzero || w_ovf) begin
              md_result <= w_special_val;
              md_valid  <= 1'b1;
              r_state   <= MD_DONE;
            end else begin
              r_cnt   <= CW'(XLEN - 1);
              r_state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (md_flush) begin
            r_state <= MD_IDLE;
          end else if (r_cnt == '0) begin
            md_result <= w_core_result;
            md_valid  <= 1'b1;
            r_state   <= MD_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        MD_DONE: begin
          if (md_flush || !md_hold) begin
            md_valid <= 1'b0;
            r_state  <= MD_IDLE;
          end
        end
        default: begin
          md_valid <= 1'b0;
          r_state  <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// Self-checking bench for md_seq: directed cases, randomized operations
// against an arithmetic reference, flush, hold, back-to-back and reset.
module tb_md_seq;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        md_start;
  logic [2:0]  md_funct3;
  logic [31:0] md_op1;
  logic [31:0] md_op2;
  logic        md_flush;
  logic        md_hold;
  logic        mult_stall;
  logic [31:0] md_result;
  logic        md_valid;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  md_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .cpurst     (cpurst),
    .md_start   (md_start),
    .md_funct3  (md_funct3),
    .md_op1     (md_op1),
    .md_op2     (md_op2),
    .md_flush   (md_flush),
    .md_hold    (md_hold),
    .mult_stall (mult_stall),
    .md_result  (md_result),
    .md_valid   (md_valid)
  );

  // Reference result from 64-bit integer arithmetic and the RISC-V M rules.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    logic [63:0] ua64, ub64;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Expected cycles from start to valid: divide special cases finish immediately.
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4 && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit chain, input int hold_n,
                        output logic [31:0] res, output int stalls, output int lat,
                        output int vcycles, output bit got);
    @(negedge clk);
    md_funct3 = f; md_op1 = a; md_op2 = b; md_start = 1'b1;
    stalls = 0; lat = -1; got = 1'b0; vcycles = 0; res = '0;
    for (int c = 0; c < 100 && !got; c++) begin
      #1;
      if (mult_stall) stalls++;
      if (md_valid) begin
        got = 1'b1; lat = c; res = md_result;
      end else begin
        @(negedge clk);
      end
    end
    if (got) begin
      vcycles = 1;
      if (hold_n > 0) begin
        md_hold = 1'b1;
        for (int h = 0; h < hold_n; h++) begin
          @(negedge clk); #1;
          if (md_valid && md_result === res) vcycles++;
        end
        md_hold = 1'b0;
      end
      if (!chain) md_start = 1'b0;
    end else begin
      md_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    cpurst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nvec++; if (md_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", md_valid); end
    nvec++; if (md_result !== 32'd0) begin nerr++; $display("FAIL reset_result got %h exp 00000000", md_result); end
    nvec++; if (mult_stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b exp 0", mult_stall); end
    @(negedge clk);
    cpurst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  tf [11] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5};
    logic [31:0] ta [11] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd100, 32'd100,
                             32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100};
    logic [31:0] tb [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7};
    logic [31:0] te [11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100,
                             32'h80000000, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
    int          tl [11] = '{33, 33, 33, 33, 1, 1, 1, 1, 33, 33, 33};
    logic [31:0] res;
    int stalls, lat, vc;
    bit got;
    for (int i = 0; i < 11; i++) begin
      run_op(tf[i], ta[i], tb[i], 1'b0, 0, res, stalls, lat, vc, got);
      nvec++; if (!got) begin nerr++; $display("FAIL dir%0d_timeout got no valid exp valid", i); end
      nvec++; if (res !== te[i]) begin nerr++; $display("FAIL dir%0d_result got %h exp %h", i, res, te[i]); end
      nvec++; if (stalls != tl[i]) begin nerr++; $display("FAIL dir%0d_stall got %0d exp %0d", i, stalls, tl[i]); end
      nvec++; if (lat != tl[i]) begin nerr++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, tl[i]); end
      @(negedge clk); #1;
      nvec++; if (md_valid !== 1'b0 || mult_stall !== 1'b0) begin
        nerr++; $display("FAIL dir%0d_after got valid=%b stall=%b exp 0/0", i, md_valid, mult_stall);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res;
    int stalls, lat, vc, sel;
    bit got;
    for (int i = 0; i < 60; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 20));
      else if (sel == 3) b = 32'd0 - 32'($urandom_range(1, 20));
      run_op(f, a, b, 1'b0, 0, res, stalls, lat, vc, got);
      nvec++; if (res !== ref_md(f, a, b) || !got) begin
        nerr++; $display("FAIL rand%0d_result f=%0d a=%h b=%h got %h exp %h", i, f, a, b, res, ref_md(f, a, b));
      end
      nvec++; if (lat != ref_lat(f, a, b)) begin
        nerr++; $display("FAIL rand%0d_latency f=%0d got %0d exp %0d", i, f, lat, ref_lat(f, a, b));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int stalls, lat, vc, seen;
    bit got;
    @(negedge clk);
    md_funct3 = 3'd5; md_op1 = 32'd1000; md_op2 = 32'd3; md_start = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    nvec++; if (mult_stall !== 1'b1) begin nerr++; $display("FAIL flush_calc_stall got %b exp 1", mult_stall); end
    md_flush = 1'b1; md_start = 1'b0;
    @(negedge clk);
    md_flush = 1'b0;
    #1;
    nvec++; if (md_valid !== 1'b0 || mult_stall !== 1'b0) begin
      nerr++; $display("FAIL flush_idle got valid=%b stall=%b exp 0/0", md_valid, mult_stall);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); #1; if (md_valid || mult_stall) seen++; end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL flush_quiet got %0d active cycles exp 0", seen); end
    run_op(3'd5, 32'd100, 32'd7, 1'b0, 0, res, stalls, lat, vc, got);
    nvec++; if (res !== 32'd14 || !got) begin nerr++; $display("FAIL flush_next_result got %h exp 0000000e", res); end
    nvec++; if (lat != 33) begin nerr++; $display("FAIL flush_next_latency got %0d exp 33", lat); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [31:0] res;
    int stalls, lat, vc;
    bit got;
    run_op(3'd0, 32'd12345, 32'd678, 1'b0, 3, res, stalls, lat, vc, got);
    nvec++; if (res !== 32'd8369910 || !got) begin nerr++; $display("FAIL hold_result got %h exp %h", res, 32'd8369910); end
    nvec++; if (vc != 4) begin nerr++; $display("FAIL hold_valid_cycles got %0d exp 4", vc); end
    @(negedge clk); #1;
    nvec++; if (md_valid !== 1'b0) begin nerr++; $display("FAIL hold_release got %b exp 0", md_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int s1, s2, l1, l2, vc;
    bit g1, g2;
    run_op(3'd3, 32'hDEADBEEF, 32'h12345678, 1'b1, 0, r1, s1, l1, vc, g1);
    run_op(3'd5, 32'hFFFF0000, 32'd13, 1'b0, 0, r2, s2, l2, vc, g2);
    nvec++; if (r1 !== ref_md(3'd3, 32'hDEADBEEF, 32'h12345678) || !g1) begin
      nerr++; $display("FAIL b2b_first got %h exp %h", r1, ref_md(3'd3, 32'hDEADBEEF, 32'h12345678));
    end
    nvec++; if (r2 !== 32'hFFFF0000 / 32'd13 || !g2) begin
      nerr++; $display("FAIL b2b_second got %h exp %h", r2, 32'hFFFF0000 / 32'd13);
    end
    nvec++; if (l2 != 33 || s2 != 33) begin
      nerr++; $display("FAIL b2b_second_timing got lat=%0d stall=%0d exp 33/33", l2, s2);
    end
    @(negedge clk);
  endtask

  task automatic test_midreset();
    logic [31:0] res;
    int stalls, lat, vc, seen;
    bit got;
    @(negedge clk);
    md_funct3 = 3'd1; md_op1 = $urandom; md_op2 = $urandom; md_start = 1'b1;
    repeat (5) @(negedge clk);
    cpurst = 1'b1; md_start = 1'b0;
    @(negedge clk);
    cpurst = 1'b0;
    #1;
    nvec++; if (md_valid !== 1'b0 || mult_stall !== 1'b0 || md_result !== 32'd0) begin
      nerr++; $display("FAIL midreset got valid=%b stall=%b result=%h exp 0/0/00000000", md_valid, mult_stall, md_result);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); #1; if (md_valid) seen++; end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL midreset_quiet got %0d valid cycles exp 0", seen); end
    run_op(3'd6, 32'hFFFFFF9C, 32'd7, 1'b0, 0, res, stalls, lat, vc, got);
    nvec++; if (res !== 32'hFFFFFFFE || !got) begin nerr++; $display("FAIL midreset_recover got %h exp fffffffe", res); end
    @(negedge clk);
  endtask

  initial begin
    cpurst = 1'b1; md_start = 1'b0; md_funct3 = '0; md_op1 = '0; md_op2 = '0;
    md_flush = 1'b0; md_hold = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_hold();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/md_seq.md
# md_seq

Sequencer for the iterative RV32M multiply/divide unit in the execute stage. It accepts a multiply/divide operation presented by the decode/execute pipeline register and runs a radix-2 shift-add multiply or restoring divide, one bit per cycle. While the operation is in flight it drives `mult_stall` to freeze the front of the pipeline. It then delivers one registered 32-bit result with a valid pulse.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; iteration counter width is `$clog2(XLEN)`.

Ports:
- `clk`  in  1  core clock.
- `cpurst`  in  1  reset; synchronous, active-high.
- `md_start`  in  1  an M-extension instruction is valid in EX (`de2ex_MD_OP_ffout & de2ex_inst_valid_ffout`).
- `md_funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `md_op1`, `md_op2`  in  XLEN  rs1/rs2 operand values.
- `md_flush`  in  1  kill the in-flight operation (branch redirect/trap).
- `md_hold`  in  1  downstream stall (`mem_stall | readram_stall`); the pipeline will not advance this cycle.
- `mult_stall`  out  1  hold the DE/EX register and earlier stages.
- `md_result`  out  XLEN  registered result.
- `md_valid`  out  1  `md_result` is valid for the instruction in EX.

## Operation
- State machine: IDLE, CALC, DONE.
- **IDLE**
  - When `md_start=1`: latch funct3 and operand magnitudes.
    - op1 is signed for MULH, MULHSU, DIV, REM.
    - op2 is signed for MULH, DIV, REM.
  - Latch the result sign: product/quotient negative = s1^s2; remainder sign = s1.
  - Load counter = XLEN-1 and go to CALC.
  - Special cases go directly to DONE with the result preloaded:
    - Divide by zero: DIV/DIVU = all ones, REM/REMU = op1.
    - Signed overflow (DIV/REM of 0x80000000 by -1): DIV = 0x80000000, REM = 0.
- **CALC**
  - Each cycle performs one step:
    - Multiply: conditional add of the multiplicand into the upper half of a 2·XLEN accumulator, then shift right.
    - Divide: shift the partial remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - Counter decrements each step.
  - At counter = 0, apply the sign fix (two's-complement negate if required) and select the result field:
    - MUL: low XLEN bits.
    - MULH*: high XLEN bits.
    - DIV*: quotient.
    - REM*: remainder.
  - Register `md_result` and go to DONE.
- **DONE**
  - `md_valid=1`.
  - If `md_hold=1`, stay in DONE with result and valid unchanged; otherwise go to IDLE.
  - `md_start` is ignored in DONE; it still reflects the completing instruction.
- `md_flush=1` in CALC or DONE: return to IDLE and drop `md_valid`. A flush takes precedence over completion in the same cycle.
- `md_flush=1` in IDLE: `md_start` is ignored that cycle.
- `mult_stall = (IDLE & md_start & !md_flush) | CALC`. It is low in DONE so the instruction retires.

## Timing
- Reset values: state IDLE, counter 0, `md_result` 0, `md_valid` 0, `mult_stall` 0.
- Reset mid-operation aborts to IDLE on the next edge; no result is produced.
- Normal operation:
  - Start accepted at edge 0.
  - CALC occupies cycles 1..XLEN.
  - DONE and `md_valid` are seen in cycle XLEN+1.
  - `mult_stall` is high for XLEN+1 cycles (33 for XLEN=32).
- Special cases: `mult_stall` high for 1 cycle; `md_valid` in the next cycle.
- Back-to-back M instructions: DONE→IDLE, then the new start is seen in the IDLE cycle. There is a 1-cycle gap, and `mult_stall` reasserts combinationally.
- `md_result` changes only on the CALC→DONE transition or an IDLE→DONE special case. It is stable while `md_hold` is high.

## Structure
- Shared package `md_pkg`:
  - funct3 constants (`MD_MUL`..`MD_REMU`).
  - State enum `md_state_t`.
  - Helpers `md_is_div(funct3)` and `md_op1_signed`/`md_op2_signed`.
- Sub-module `md_core`: the one-bit-per-step datapath (accumulator, partial remainder, quotient shift register, final negate/select).
  - Inputs: `load`, `step`, `finish`.
  - Output: the selected result.
- `md_seq` owns the FSM, the counter, special-case detection and handshakes.

## Test plan
- MUL 7 × 0xFFFFFFFD → `md_result` 0xFFFFFFEB.
  - `mult_stall` high exactly 33 cycles.
  - `md_valid` pulse on cycle 34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIVU 100 / 0 → 0xFFFFFFFF, and REMU 100 / 0 → 100, each with 1 stall cycle.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0, with 1 stall cycle.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF.
- Flush at CALC cycle 10 → IDLE next cycle, no `md_valid`, `mult_stall` low. A following DIVU 100 / 7 → 14 is correct.
- `md_hold` high 3 cycles in DONE → `md_valid` and `md_result` held 4 cycles.
- `cpurst` pulse mid-CALC → all outputs 0 next cycle.
